sort4_signed_ctrl: RTL and testbench

Sequential controller that sorts four signed two's-complement values into ascending order using one shared signed magnitude comparator (`comp_sign`). It performs a bubble sort, issuing one comparison per clock and exiting early when a pass makes no swaps. It sits in front of the Lab 5 comparator datapath and is the first block that sequences that comparator rather than driving it from a bench.

---
 rtl/sort4_signed_ctrl_pkg.sv | 18 +
 rtl/sort4_signed_ctrl_comp_sign.sv | 25 ++
 rtl/sort4_signed_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sort4_signed_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sort4_signed_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sort4_signed_ctrl_pkg
// Shared definitions for the four-element signed bubble-sort controller:
// FSM state encoding and element / swap-count constants.
// -----------------------------------------------------------------------------
package sort4_signed_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int N_ELEM    = 4;
  localparam int MAX_SWAPS = 6;
  localparam int CMP_WIDTH = 4;

endpackage : sort4_signed_ctrl_pkg

// File: rtl/sort4_signed_ctrl_comp_sign.sv
// -----------------------------------------------------------------------------
// comp_sign
// Signed two's-complement magnitude comparator.
// Ports:
//   A, B : signed operands, WIDTH bits each
//   Gt   : A >  B
//   Eq   : A == B
//   Lt   : A <  B
// -----------------------------------------------------------------------------
module comp_sign #(
  parameter int WIDTH = 4
) (
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  output logic                    Gt,
  output logic                    Eq,
  output logic                    Lt
);

  // Both operands are declared signed, so these are signed comparisons.
  assign Gt = (A > B);
  assign Eq = (A == B);
  assign Lt = (A < B);

endmodule : comp_sign

// File: rtl/sort4_signed_ctrl.sv
// -----------------------------------------------------------------------------
// sort4_signed_ctrl
// Sorts four signed values into ascending order with a bubble sort that shares
// a single comp_sign comparator, one compare per clock. With EARLY_EXIT set,
// the sort stops after the first pass that makes no swaps.
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   start             : accepted only in IDLE; captures din0..din3
//   din0..din3        : signed operands (din0 is index 0)
//   busy              : high from the accept edge until done is driven
//   done              : one-cycle pulse, results valid
//   dout0..dout3      : ascending results (dout0 = minimum), held until next done
//   swaps             : number of swaps made by the last sort (0..6)
// -----------------------------------------------------------------------------
module sort4_signed_ctrl
  import sort4_signed_ctrl_pkg::*;
#(
  parameter int WIDTH      = CMP_WIDTH,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] din0,
  input  logic signed [WIDTH-1:0] din1,
  input  logic signed [WIDTH-1:0] din2,
  input  logic signed [WIDTH-1:0] din3,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] dout0,
  output logic signed [WIDTH-1:0] dout1,
  output logic signed [WIDTH-1:0] dout2,
  output logic signed [WIDTH-1:0] dout3,
  output logic [2:0]              swaps
);

  state_e                  state_q;
  logic signed [WIDTH-1:0] r_q    [N_ELEM];
  logic signed [WIDTH-1:0] dout_q [N_ELEM];
  logic [1:0]              i_q;
  logic [1:0]              pass_end_q;
  logic                    swapped_q;
  logic [2:0]              cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic [2:0]              swaps_q;

  // Combinational next-state of the working set for the current compare.
  logic signed [WIDTH-1:0] op_a;
  logic signed [WIDTH-1:0] op_b;
  logic signed [WIDTH-1:0] r_d [N_ELEM];
  logic                    gt;
  logic                    swapped_d;
  logic [2:0]              cnt_d;
  logic                    pass_last;
  logic                    finish;
  logic [1:0]              i_nxt;

  // i never exceeds pass_end (<= 2) while comparing, so i+1 stays in range.
  assign i_nxt = i_q + 2'd1;
  assign op_a  = r_q[i_q];
  assign op_b  = r_q[i_nxt];

  comp_sign #(
    .WIDTH (WIDTH)
  ) u_comp (
    .A  (op_a),
    .B  (op_b),
    .Gt (gt),
    .Eq (),
    .Lt ()
  );

  // NOTE: every combinational output gets a default before any conditional
  // assignment so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    r_d = r_q;
    if (gt) begin
      r_d[i_q]   = op_b;
      r_d[i_nxt] = op_a;
    end
  end

  // Equal operands give gt=0, so ties are never swapped and the sort is stable.
  assign swapped_d = swapped_q | gt;
  assign cnt_d     = cnt_q + {2'b00, gt};
  assign pass_last = (i_q == pass_end_q);
  // The swap made in the current cycle counts toward this pass.
  assign finish    = pass_last && ((pass_end_q == 2'd0) || (EARLY_EXIT && !swapped_d));

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      pass_end_q <= '0;
      swapped_q  <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      swaps_q    <= '0;
      // NOTE: these arrays are four flops each, not a RAM, so they are reset
      // explicitly; an aborted sort must not leave stale results visible.
      for (int k = 0; k < N_ELEM; k++) begin
        r_q[k]    <= '0;
        dout_q[k] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            r_q[0]     <= din0;
            r_q[1]     <= din1;
            r_q[2]     <= din2;
            r_q[3]     <= din3;
            i_q        <= 2'd0;
            pass_end_q <= 2'd2;
            swapped_q  <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_CMP;
          end
        end

        ST_CMP: begin
          r_q   <= r_d;
          cnt_q <= cnt_d;
          if (pass_last) begin
            if (finish) begin
              // Results are published on the final compare edge so that done
              // and the new dout/swaps values appear in the same cycle.
              dout_q  <= r_d;
              swaps_q <= cnt_d;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              pass_end_q <= pass_end_q - 2'd1;
              i_q        <= 2'd0;
              swapped_q  <= 1'b0;
            end
          end else begin
            i_q       <= i_nxt;
            swapped_q <= swapped_d;
          end
        end

        ST_DONE: begin
          // start is ignored here; a new sort can be accepted next cycle.
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign dout0 = dout_q[0];
  assign dout1 = dout_q[1];
  assign dout2 = dout_q[2];
  assign dout3 = dout_q[3];
  assign swaps = swaps_q;

endmodule : sort4_signed_ctrl

// File: tb/tb_sort4_signed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sort4_signed_ctrl
// Scoreboard bench: expected results come from a reference bubble sort and are
// queued at the start edge; monitors pop and compare on every done pulse.
// A second instance with EARLY_EXIT=0 checks the fixed six-compare schedule.
// -----------------------------------------------------------------------------
module tb_sort4_signed_ctrl;

  typedef struct packed {
    logic [3:0][3:0] d;
    logic [2:0]      sw;
    int              lat;
    int              st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start_e = 1'b0;
  logic [3:0] din0 = '0, din1 = '0, din2 = '0, din3 = '0;
  logic       busy, done, busy_e, done_e;
  logic [3:0] dout0, dout1, dout2, dout3;
  logic [3:0] eout0, eout1, eout2, eout3;
  logic [2:0] swaps, swaps_e;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q[$];
  exp_t qe[$];

  sort4_signed_ctrl #(.WIDTH(4), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .busy(busy), .done(done),
    .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .swaps(swaps)
  );

  sort4_signed_ctrl #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start_e),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .busy(busy_e), .done(done_e),
    .dout0(eout0), .dout1(eout1), .dout2(eout2), .dout3(eout3),
    .swaps(swaps_e)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference bubble sort with optional early exit; latency = compares + 1.
  function automatic exp_t model(input int a[4], input bit ee, input int st);
    exp_t e;
    int   v[4];
    int   t, sw, cmps;
    bit   s;
    for (int k = 0; k < 4; k++) v[k] = a[k];
    sw = 0;
    cmps = 0;
    for (int pe = 2; pe >= 0; pe--) begin
      s = 1'b0;
      for (int j = 0; j <= pe; j++) begin
        cmps++;
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
          s = 1'b1;
          sw++;
        end
      end
      if (ee && !s) break;
    end
    for (int k = 0; k < 4; k++) e.d[k] = v[k][3:0];
    e.sw  = sw[2:0];
    e.lat = cmps + 1;
    e.st  = st;
    return e;
  endfunction

  task automatic score(input string p, input exp_t e, input logic [3:0] d0,
                       input logic [3:0] d1, input logic [3:0] d2,
                       input logic [3:0] d3, input logic [2:0] sw, input int bc);
    check({p, "dout0"}, int'($signed(d0)), int'($signed(e.d[0])));
    check({p, "dout1"}, int'($signed(d1)), int'($signed(e.d[1])));
    check({p, "dout2"}, int'($signed(d2)), int'($signed(e.d[2])));
    check({p, "dout3"}, int'($signed(d3)), int'($signed(e.d[3])));
    check({p, "swaps"}, int'(sw), int'(e.sw));
    check({p, "latency"}, cyc - e.st + 1, e.lat);
    check({p, "busy_cycles"}, bc, e.lat - 1);
  endtask

  // Monitor for the early-exit instance.
  initial begin
    int   bc;
    exp_t e;
    bc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bc = 0;
      end else begin
        if (busy) bc++;
        if (done) begin
          check("busy_low_in_done", int'(busy), 0);
          if (q.size() == 0) check("unexpected_done", 1, 0);
          else begin
            e = q.pop_front();
            score("", e, dout0, dout1, dout2, dout3, swaps, bc);
          end
          bc = 0;
        end
      end
    end
  end

  // Monitor for the EARLY_EXIT=0 instance.
  initial begin
    int   bc;
    exp_t e;
    bc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bc = 0;
      end else begin
        if (busy_e) bc++;
        if (done_e) begin
          if (qe.size() == 0) check("full_unexpected_done", 1, 0);
          else begin
            e = qe.pop_front();
            score("full_", e, eout0, eout1, eout2, eout3, swaps_e, bc);
          end
          bc = 0;
        end
      end
    end
  end

  // Called at a negedge: presents operands, pulses start for one cycle.
  task automatic launch(input int a[4], input bit both);
    din0 = a[0][3:0];
    din1 = a[1][3:0];
    din2 = a[2][3:0];
    din3 = a[3][3:0];
    start = 1'b1;
    q.push_back(model(a, 1'b1, cyc + 1));
    if (both) begin
      start_e = 1'b1;
      qe.push_back(model(a, 1'b0, cyc + 1));
    end
    @(negedge clk);
    start   = 1'b0;
    start_e = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && (q.size() != 0 || qe.size() != 0); n++) @(negedge clk);
    check("drain_pending", q.size() + qe.size(), 0);
    q.delete();
    qe.delete();
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string p);
    check({p, "busy"},  int'(busy),  0);
    check({p, "done"},  int'(done),  0);
    check({p, "swaps"}, int'(swaps), 0);
    check({p, "dout0"}, int'(dout0), 0);
    check({p, "dout1"}, int'(dout1), 0);
    check({p, "dout2"}, int'(dout2), 0);
    check({p, "dout3"}, int'(dout3), 0);
  endtask

  initial begin
    int         mix[4]    = '{1, -1, 7, -2};
    int         sorted[4] = '{-8, -1, 0, 7};
    int         rev[4]    = '{7, 3, -1, -8};
    int         dup[4]    = '{-1, -1, -1, -1};
    int         rnd[4];
    logic [3:0] nib;
    bit         seen;

    #1;
    check_zero_outputs("reset_");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch(mix, 1'b0);    wait_idle();
    launch(sorted, 1'b1); wait_idle();
    launch(rev, 1'b1);    wait_idle();
    launch(dup, 1'b1);    wait_idle();

    // start with new operands at cycles 2 and 3 of an active sort is ignored.
    launch(mix, 1'b0);
    din0 = 4'd7; din1 = 4'd7; din2 = 4'd7; din3 = 4'd8;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // start in the DONE cycle is ignored; start in the next cycle is accepted.
    launch(sorted, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check("b2b_done_seen", int'(seen), 1);
    din0 = rev[0][3:0]; din1 = rev[1][3:0]; din2 = rev[2][3:0]; din3 = rev[3][3:0];
    start = 1'b1;
    @(negedge clk);
    launch(mix, 1'b0);
    wait_idle();

    // Reset mid-sort: outputs clear immediately, no done is ever issued.
    launch(rev, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort_");
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", int'(seen), 0);
    launch(rev, 1'b0);
    wait_idle();

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 4; k++) begin
        nib    = 4'($urandom_range(0, 15));
        rnd[k] = int'($signed(nib));
      end
      launch(rnd, 1'b1);
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sort4_signed_ctrl
